// File: rtl/serial_feeder.sv
`default_nettype none
// ============================================================================
// Module      : serial_feeder
// Description : Small word FIFO feeding a parallel-to-serial shifter. It
//               streams buffered words gaplessly, one bit per enabled cycle,
//               on a registered ser_data/ser_valid pair.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_feeder #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             en,
  input  logic                             flush,
  output logic                             ser_data,
  output logic                             ser_valid,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int REM_W = $clog2(DATA_W + 1);
  localparam logic [LVL_W-1:0] C_FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [REM_W-1:0] C_LOAD_REM = REM_W'(DATA_W - 1);
  localparam logic             C_LSB      = (LSB_FIRST != 0);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_valid_q, ser_valid_d;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;

  // Handshake and pop decision; a pop only happens once the current word is done.
  always_comb begin
    w_full   = (level_q == C_FULL_LVL);
    w_empty  = (level_q == '0);
    in_ready = !w_full && !flush && rst;
    w_push   = in_valid && in_ready;
    w_pop    = en && !flush && (rem_q == '0) && !w_empty;
    w_head   = mem_q[rd_ptr_q];
  end

  // FIFO pointer and occupancy update; flush discards everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Serializer: continue the in-flight word, else load the head word and emit its first bit.
  always_comb begin
    shift_d     = shift_q;
    rem_d       = rem_q;
    ser_data_d  = ser_data_q;
    ser_valid_d = 1'b0;
    if (flush) begin
      rem_d = '0;
    end else if (en) begin
      if (rem_q != '0) begin
        ser_data_d  = C_LSB ? shift_q[0] : shift_q[DATA_W-1];
        shift_d     = C_LSB ? (shift_q >> 1) : (shift_q << 1);
        ser_valid_d = 1'b1;
        rem_d       = rem_q - REM_W'(1);
      end else if (w_pop) begin
        ser_data_d  = C_LSB ? w_head[0] : w_head[DATA_W-1];
        shift_d     = C_LSB ? (w_head >> 1) : (w_head << 1);
        ser_valid_d = 1'b1;
        rem_d       = C_LOAD_REM;
      end
    end
  end

  // Word storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= in_data;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      shift_q     <= '0;
      rem_q       <= '0;
      ser_data_q  <= 1'b0;
      ser_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      shift_q     <= shift_d;
      rem_q       <= rem_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
    end
  end

  // Output drive.
  always_comb begin
    ser_data   = ser_data_q;
    ser_valid  = ser_valid_q;
    busy       = (rem_q != '0) || !w_empty;
    fifo_level = level_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_feeder
// Description : Self-checking bench for serial_feeder with a queue-based
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_feeder;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_ready, en, flush;
  logic       ser_data, ser_valid, busy;
  logic [2:0] fifo_level;

  logic [7:0] b_in_data;
  logic       b_in_valid, b_in_ready, b_en, b_flush;
  logic       b_ser_data, b_ser_valid, b_busy;
  logic [2:0] b_fifo_level;

  int checks;
  int errors;

  // reference model state
  logic [7:0] m_fifo[$];
  logic       m_bits[$];
  logic       m_data, m_valid, m_ready, m_accept, obs_ready;

  serial_feeder #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1)) dut (
    .clk(clk), .rst(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .en(en), .flush(flush), .ser_data(ser_data),
    .ser_valid(ser_valid), .busy(busy), .fifo_level(fifo_level)
  );

  serial_feeder #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .en(b_en), .flush(b_flush), .ser_data(b_ser_data),
    .ser_valid(b_ser_valid), .busy(b_busy), .fifo_level(b_fifo_level)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and advance the model by the same edge.
  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic e, input logic f);
    logic [7:0] w;
    in_valid = v; in_data = d; en = e; flush = f;
    m_ready = (m_fifo.size() < DEPTH) && !f;
    #1 obs_ready = in_ready;
    @(posedge clk);
    m_accept = v && m_ready;
    if (f) begin
      m_fifo.delete();
      m_bits.delete();
      m_valid = 1'b0;
    end else begin
      if (e && m_bits.size() > 0) begin
        m_data  = m_bits.pop_front();
        m_valid = 1'b1;
      end else if (e && m_fifo.size() > 0) begin
        w = m_fifo.pop_front();
        for (int i = 0; i < 8; i++) m_bits.push_back(w[i]);
        m_data  = m_bits.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (m_accept) m_fifo.push_back(d);
    end
    #1;
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_bits.delete();
    m_data  = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({ser_data, ser_valid, busy, in_ready, fifo_level} !== 7'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b required 0000000", c,
                 {ser_data, ser_valid, busy, in_ready, fifo_level});
      end
      checks++;
      if (b_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_msb_ready: got %b required 0", b_in_ready);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy, ser_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: got ready/busy/valid %b required 100", {in_ready, busy, ser_valid});
    end
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    w = 8'hB4;
    drive_cycle(1'b1, w, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (ser_valid !== 1'b1 || ser_data !== w[i]) begin
        errors++;
        $display("FAIL single_bit %0d: got valid=%b data=%b required valid=1 data=%b", i, ser_valid, ser_data, w[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_after_last: got %b required 0", busy);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_valid_after: got %b required 0", ser_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [6];
    logic       exp_bits[$];
    int idx, before_drop, nvalid, first, last, k;
    words[0] = 8'h0F; words[1] = 8'hF0; words[2] = 8'hA5;
    words[3] = 8'h3C; words[4] = 8'h99; words[5] = 8'h66;
    for (int j = 0; j < 6; j++)
      for (int b = 0; b < 8; b++) exp_bits.push_back(words[j][b]);
    idx = 0; before_drop = -1; nvalid = 0; first = -1; last = -1; k = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      drive_cycle(idx < 6, words[(idx < 6) ? idx : 5], 1'b1, 1'b0);
      if (!obs_ready && idx < 6 && before_drop < 0) before_drop = idx;
      checks++;
      if (obs_ready !== m_ready) begin
        errors++;
        $display("FAIL b2b_ready cycle %0d: got %b required %b", cyc, obs_ready, m_ready);
      end
      if (m_accept) idx++;
      if (ser_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = cyc;
        last = cyc;
        if (k < 48) begin
          checks++;
          if (ser_data !== exp_bits[k]) begin
            errors++;
            $display("FAIL b2b_bit %0d: got %b required %b", k, ser_data, exp_bits[k]);
          end
        end
        k++;
      end
    end
    checks++;
    if (before_drop !== 5) begin
      errors++;
      $display("FAIL b2b_accepted_before_stall: got %0d required 5", before_drop);
    end
    checks++;
    if (idx !== 6) begin
      errors++;
      $display("FAIL b2b_all_accepted: got %0d required 6", idx);
    end
    checks++;
    if (nvalid !== 48 || (last - first + 1) !== 48) begin
      errors++;
      $display("FAIL b2b_contiguous: got %0d valid over span %0d required 48 over 48", nvalid, last - first + 1);
    end
    checks++;
    if (busy !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL b2b_drained: got busy=%b level=%0d required 0 0", busy, fifo_level);
    end
  endtask

  task automatic test_pause();
    logic [7:0] w;
    w = 8'hC3;
    drive_cycle(1'b1, w, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (ser_valid !== 1'b1 || ser_data !== w[i]) begin
        errors++;
        $display("FAIL pause_pre_bit %0d: got valid=%b data=%b required 1 %b", i, ser_valid, ser_data, w[i]);
      end
    end
    for (int p = 0; p < 3; p++) begin
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      checks++;
      if (ser_valid !== 1'b0 || busy !== 1'b1 || ser_data !== w[2]) begin
        errors++;
        $display("FAIL pause_hold %0d: got valid=%b busy=%b data=%b required 0 1 %b", p, ser_valid, busy, ser_data, w[2]);
      end
    end
    for (int i = 3; i < 8; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (ser_valid !== 1'b1 || ser_data !== w[i]) begin
        errors++;
        $display("FAIL pause_post_bit %0d: got valid=%b data=%b required 1 %b", i, ser_valid, ser_data, w[i]);
      end
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (ser_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pause_end: got valid=%b busy=%b required 0 0", ser_valid, busy);
    end
  endtask

  task automatic test_flush_and_reset();
    logic [7:0] w;
    w = 8'h01;
    for (int pass = 0; pass < 2; pass++) begin
      drive_cycle(1'b1, 8'h5A, 1'b1, 1'b0);
      drive_cycle(1'b1, 8'h11, 1'b1, 1'b0);
      drive_cycle(1'b1, 8'h22, 1'b1, 1'b0);
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (fifo_level !== 3'd2 || busy !== 1'b1 || ser_valid !== 1'b1) begin
        errors++;
        $display("FAIL discard_setup pass %0d: got level=%0d busy=%b valid=%b required 2 1 1", pass, fifo_level, busy, ser_valid);
      end
      if (pass == 0) begin
        drive_cycle(1'b1, 8'hEE, 1'b1, 1'b1);
        checks++;
        if (obs_ready !== 1'b0) begin
          errors++;
          $display("FAIL flush_ready: got %b required 0", obs_ready);
        end
      end else begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (in_ready !== 1'b0 || ser_data !== 1'b0) begin
          errors++;
          $display("FAIL async_reset_immediate: got ready=%b data=%b required 0 0", in_ready, ser_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
      end
      checks++;
      if (ser_valid !== 1'b0 || fifo_level !== 3'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL discard_state pass %0d: got valid=%b level=%0d busy=%b required 0 0 0", pass, ser_valid, fifo_level, busy);
      end
      drive_cycle(1'b1, w, 1'b1, 1'b0);
      checks++;
      if (obs_ready !== 1'b1) begin
        errors++;
        $display("FAIL discard_repush_ready pass %0d: got %b required 1", pass, obs_ready);
      end
      for (int i = 0; i < 8; i++) begin
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (ser_valid !== 1'b1 || ser_data !== w[i]) begin
          errors++;
          $display("FAIL discard_repush_bit pass %0d bit %0d: got valid=%b data=%b required 1 %b", pass, i, ser_valid, ser_data, w[i]);
        end
      end
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (ser_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL discard_repush_end pass %0d: got valid=%b busy=%b required 0 0", pass, ser_valid, busy);
      end
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] w;
    w = 8'hB4;
    b_en = 1'b1; b_in_data = w; b_in_valid = 1'b1;
    #1;
    checks++;
    if (b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL msb_ready: got %b required 1", b_in_ready);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (b_ser_valid !== 1'b1 || b_ser_data !== w[7-i]) begin
        errors++;
        $display("FAIL msb_bit %0d: got valid=%b data=%b required 1 %b", i, b_ser_valid, b_ser_data, w[7-i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (b_ser_valid !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL msb_end: got valid=%b busy=%b required 0 0", b_ser_valid, b_busy);
    end
    b_en = 1'b0;
  endtask

  task automatic test_random();
    logic       v, e, f;
    logic [7:0] d;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      e = ($urandom_range(0, 4) != 0);
      f = ($urandom_range(0, 39) == 0);
      drive_cycle(v, d, e, f);
      checks++;
      if (obs_ready !== m_ready) begin
        errors++;
        $display("FAIL rand_ready cycle %0d: got %b required %b", c, obs_ready, m_ready);
      end
      checks++;
      if (ser_valid !== m_valid || ser_data !== m_data) begin
        errors++;
        $display("FAIL rand_serial cycle %0d: got valid=%b data=%b required %b %b", c, ser_valid, ser_data, m_valid, m_data);
      end
      checks++;
      if (fifo_level !== 3'(m_fifo.size()) || busy !== (m_bits.size() > 0 || m_fifo.size() > 0)) begin
        errors++;
        $display("FAIL rand_level cycle %0d: got level=%0d busy=%b required %0d %b", c, fifo_level, busy,
                 m_fifo.size(), (m_bits.size() > 0 || m_fifo.size() > 0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    in_data = '0; in_valid = 1'b0; en = 1'b0; flush = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_en = 1'b0; b_flush = 1'b0;
    checks = 0; errors = 0;
    m_data = 1'b0; m_valid = 1'b0; m_ready = 1'b0; m_accept = 1'b0; obs_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_pause();
    test_flush_and_reset();
    test_msb_first();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
